// File: rtl/lsnn_syn_current_if.sv
// Purpose : bundles the spike, weight-write, run-control and current signals of lsnn_syn_current.
// Latency : n/a (wires only).
// Backpressure: weight writes are accepted only while wr_ready is high; other signals are unflowcontrolled.
// Ports   : spike_in[N_SYN], wr_en/wr_addr/wr_data/wr_ready, run_en,
//           current_out[8], current_valid, sat_flag.
interface lsnn_syn_current_if #(
  parameter int N_SYN = 8
);
  logic [N_SYN-1:0] spike_in;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             run_en;
  logic [7:0]       current_out;
  logic             current_valid;
  logic             sat_flag;

  // master drives stimulus and consumes the current; slave is the synapse stage
  modport master (
    output spike_in, wr_en, wr_addr, wr_data, run_en,
    input  wr_ready, current_out, current_valid, sat_flag
  );

  modport slave (
    input  spike_in, wr_en, wr_addr, wr_data, run_en,
    output wr_ready, current_out, current_valid, sat_flag
  );
endinterface

// File: rtl/lsnn_syn_current.sv
// Purpose : weighted presynaptic spike sum integrated into a decaying, saturating 8-bit synaptic current.
// Latency : spike_in sampled at edge k is reflected in current_out right after edge k (1 cycle).
// Backpressure: none on spikes; weight writes only accepted in IDLE (wr_ready), dropped otherwise.
// Ports   : clk, rst_n (synchronous, active-high despite the name),
//           bus (slave): spike_in, wr_en/wr_addr/wr_data/wr_ready, run_en,
//           current_out, current_valid, sat_flag.
module lsnn_syn_current #(
  parameter int         N_SYN       = 8,
  parameter int         DECAY_SHIFT = 1,
  parameter logic [7:0] WEIGHT_INIT = 8'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  lsnn_syn_current_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [7:0]  w_q [N_SYN];
  logic [7:0]  cur_q;
  logic        sat_q;

  logic [10:0] sum;   // up to 8 x 255 = 2040
  logic [11:0] nxt;   // decayed current + sum can exceed 11 bits (127 + 2040)
  logic        wr_accept;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.run_en ? RUN : IDLE;
      RUN:     state_d = bus.run_en ? RUN : DRAIN;
      // Leave DRAIN only once the current has fully decayed, unless re-armed
      DRAIN:   state_d = bus.run_en ? RUN : ((cur_q == 8'd0) ? IDLE : DRAIN);
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    bus.wr_ready      = (state_q == IDLE);
    bus.current_valid = (state_q != IDLE);
    bus.current_out   = cur_q;
    bus.sat_flag      = sat_q;
  end

  // ---------------- weight RAM ----------------
  assign wr_accept = bus.wr_en && (state_q == IDLE);

  // Address compare per entry: an out-of-range wr_addr matches nothing and is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_SYN; i++) begin
        w_q[i] <= WEIGHT_INIT;
      end
    end else begin
      for (int i = 0; i < N_SYN; i++) begin
        if (wr_accept && (bus.wr_addr == 3'(i))) begin
          w_q[i] <= bus.wr_data;
        end
      end
    end
  end

  // ---------------- weighted spike sum ----------------
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (bus.spike_in[i]) begin
        sum = sum + {3'b000, w_q[i]};
      end
    end
  end

  assign nxt = {4'b0000, (cur_q >> DECAY_SHIFT)} + {1'b0, sum};

  // ---------------- current integrator ----------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur_q <= 8'd0;
      sat_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // The RUN->DRAIN transition cycle still integrates spikes
          if (nxt > 12'd255) begin
            cur_q <= 8'd255;
            sat_q <= 1'b1;
          end else begin
            cur_q <= nxt[7:0];
            sat_q <= 1'b0;
          end
        end
        DRAIN: begin
          cur_q <= cur_q >> DECAY_SHIFT;
          sat_q <= 1'b0;
        end
        default: begin
          cur_q <= 8'd0;
          sat_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
